// File: rtl/value_membank_param.sv
// value_membank_param
//   Multi-channel value store: NCH independent W-bit channels, each 1<<AW
//   words deep. All channels share one read address and one write address,
//   and each channel has its own write enable. A start_init pulse fills
//   every word of every channel with FILL, from the top address down to 0.
//   While the fill runs, user reads and writes are dropped and flagged.
// Ports
//   clk, nrst     clock; synchronous active-low reset
//   start_init    pulse that begins, or restarts, the fill
//   wren/wraddr/wdata   per-channel write; channel i uses wdata[i*W +: W]
//   rd_en/rdaddr  read request; rdata/rd_valid return one cycle later
//   busy          high while the fill is running
//   done_init     one-cycle pulse after the fill writes address 0
//   wr_drop       one-cycle pulse: a write was discarded while busy
//   rd_drop       one-cycle pulse: a read was discarded while busy

// One channel: simple dual-port RAM with a registered, read-first output.
module value_membank_chan #(
    parameter int W  = 64,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [1<<AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // The output register is reset; the array contents are not.
    always_ff @(posedge clk) begin
        if (!nrst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end
endmodule

module value_membank_param #(
    parameter int NCH = 4,
    parameter int W   = 64,
    parameter int AW  = 10,
    parameter logic [W-1:0] FILL = '0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start_init,
    input  logic [NCH-1:0]   wren,
    input  logic [AW-1:0]    wraddr,
    input  logic [NCH*W-1:0] wdata,
    input  logic             rd_en,
    input  logic [AW-1:0]    rdaddr,
    output logic [NCH*W-1:0] rdata,
    output logic             rd_valid,
    output logic             busy,
    output logic             done_init,
    output logic             wr_drop,
    output logic             rd_drop
);
    logic [AW-1:0] fill_cnt;
    logic          fill_we;
    logic          user_ok;
    logic          rd_acc;

    // RAM writes are gated by nrst so that a reset edge never lands a
    // stray fill word or user write.
    assign fill_we = nrst & busy;
    assign user_ok = nrst & ~busy;
    assign rd_acc  = user_ok & rd_en;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            busy      <= 1'b0;
            done_init <= 1'b0;
            rd_valid  <= 1'b0;
            wr_drop   <= 1'b0;
            rd_drop   <= 1'b0;
            fill_cnt  <= '1;
        end else begin
            rd_valid  <= rd_acc;
            wr_drop   <= busy & (|wren);
            rd_drop   <= busy & rd_en;
            done_init <= 1'b0;
            // A start during a pass reloads the counter. The pass it aborts
            // never reaches the done branch, so that pass raises no done_init.
            if (start_init) begin
                busy     <= 1'b1;
                fill_cnt <= '1;
            end else if (busy) begin
                if (fill_cnt == '0) begin
                    busy      <= 1'b0;
                    done_init <= 1'b1;
                    fill_cnt  <= '1;
                end else begin
                    fill_cnt <= fill_cnt - 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        value_membank_chan #(.W(W), .AW(AW)) u_chan (
            .clk   (clk),
            .nrst  (nrst),
            .we    (fill_we | (user_ok & wren[g])),
            .waddr (busy ? fill_cnt : wraddr),
            .wdata (busy ? FILL : wdata[g*W +: W]),
            .re    (rd_acc),
            .raddr (rdaddr),
            .rdata (rdata[g*W +: W])
        );
    end
endmodule

// File: tb/tb_value_membank_param.sv
module tb_value_membank_param;
    localparam int NCH   = 4;
    localparam int W     = 64;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam logic [W-1:0] FILL = 64'hC0DE_5A5A_0F0F_1234;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             start_init = 1'b0;
    logic [NCH-1:0]   wren = '0;
    logic [AW-1:0]    wraddr = '0;
    logic [NCH*W-1:0] wdata = '0;
    logic             rd_en = 1'b0;
    logic [AW-1:0]    rdaddr = '0;
    logic [NCH*W-1:0] rdata;
    logic             rd_valid, busy, done_init, wr_drop, rd_drop;

    value_membank_param #(.NCH(NCH), .W(W), .AW(AW), .FILL(FILL)) dut (
        .clk(clk), .nrst(nrst), .start_init(start_init), .wren(wren),
        .wraddr(wraddr), .wdata(wdata), .rd_en(rd_en), .rdaddr(rdaddr),
        .rdata(rdata), .rd_valid(rd_valid), .busy(busy), .done_init(done_init),
        .wr_drop(wr_drop), .rd_drop(rd_drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: array contents plus a count of fill cycles remaining.
    logic [W-1:0]     mm [NCH][DEPTH];
    bit               m_busy = 0;
    int               m_left = 0;
    bit               e_done, e_rdv, e_wrd, e_rdd;
    logic [NCH*W-1:0] m_rdata = '0;
    int               m_done_cnt = 0;
    int               done_seen  = 0;
    logic [NCH*W-1:0] exp_q [$];

    task automatic chk(input string name, input logic [NCH*W-1:0] act, input logic [NCH*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model over the edge, then
    // compare the flag and hold outputs on the following falling edge.
    task automatic cyc(input bit st, input logic [NCH-1:0] we, input logic [AW-1:0] wa,
                       input logic [NCH*W-1:0] wd, input bit re, input logic [AW-1:0] ra);
        logic [NCH*W-1:0] rv;
        start_init = st; wren = we; wraddr = wa; wdata = wd; rd_en = re; rdaddr = ra;
        if (!nrst) begin
            m_busy = 0; m_left = 0; e_done = 0; e_rdv = 0; e_wrd = 0; e_rdd = 0;
            m_rdata = '0;
        end else begin
            e_rdv = re && !m_busy;
            e_rdd = re && m_busy;
            e_wrd = m_busy && (we != '0);
            if (e_rdv) begin
                for (int c = 0; c < NCH; c++) rv[c*W +: W] = mm[c][ra];
                exp_q.push_back(rv);
                m_rdata = rv;
            end
            e_done = 0;
            if (m_busy) begin
                // Fill visits DEPTH-1 first and address 0 last.
                for (int c = 0; c < NCH; c++) mm[c][m_left-1] = FILL;
                m_left--;
            end else begin
                for (int c = 0; c < NCH; c++) if (we[c]) mm[c][wa] = wd[c*W +: W];
            end
            if (st) begin
                m_busy = 1; m_left = DEPTH;
            end else if (m_busy && m_left == 0) begin
                m_busy = 0; e_done = 1; m_done_cnt++;
            end
        end
        @(negedge clk);
        chk("busy", {255'd0, busy}, {255'd0, m_busy});
        chk("done_init", {255'd0, done_init}, {255'd0, e_done});
        chk("rd_valid", {255'd0, rd_valid}, {255'd0, e_rdv});
        chk("wr_drop", {255'd0, wr_drop}, {255'd0, e_wrd});
        chk("rd_drop", {255'd0, rd_drop}, {255'd0, e_rdd});
        chk("rdata_hold", rdata, m_rdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, '0, '0, 0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cyc(0, '0, '0, '0, 1, a);
    endtask

    // Monitor: every valid read result is matched against the scoreboard.
    always @(negedge clk) begin
        if (done_init === 1'b1) done_seen++;
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", {255'd0, rd_valid}, '0);
            end else begin
                chk("rdata", rdata, exp_q.pop_front());
            end
        end
    end

    logic [NCH*W-1:0] rnd;

    initial begin
        @(negedge clk);
        nrst = 0;
        idle(2);
        nrst = 1;

        // 1: full fill, then every address reads FILL
        cyc(1, '0, '0, '0, 0, '0);
        idle(DEPTH + 1);
        for (int a = 0; a < DEPTH; a++) rd(AW'(a));

        // 2: masked channel write
        cyc(0, 4'b0101, 4'd3, {64'd4, 64'd3, 64'd2, 64'd1}, 0, '0);
        rd(4'd3);
        idle(1);

        // 3: read-first on a same-address collision
        cyc(0, 4'b1111, 4'd5, {4{64'hAA}}, 0, '0);
        cyc(0, 4'b1111, 4'd5, {4{64'hBB}}, 1, 4'd5);
        rd(4'd5);
        idle(1);

        // 4: accesses during busy are dropped; pre-init data is overwritten
        cyc(0, 4'b1111, 4'd7, {4{64'h77}}, 0, '0);
        cyc(1, '0, '0, '0, 0, '0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 4'b1111, AW'(i), {4{64'hEE}}, 1, AW'(i));
        rd(4'd7);
        rd(4'd0);
        idle(1);

        // 5: restart at busy cycle 8
        cyc(1, '0, '0, '0, 0, '0);
        idle(7);
        cyc(1, '0, '0, '0, 0, '0);
        idle(DEPTH + 2);

        // 6: reset mid-fill, then a clean fill
        cyc(0, 4'b1111, 4'd2, {4{64'h22}}, 0, '0);
        rd(4'd2);
        cyc(1, '0, '0, '0, 0, '0);
        idle(4);
        nrst = 0;
        idle(1);
        nrst = 1;
        idle(1);
        cyc(1, '0, '0, '0, 0, '0);
        idle(DEPTH + 1);
        for (int a = 0; a < DEPTH; a++) rd(AW'(a));

        // Randomized traffic, with occasional restarts of the fill
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NCH*2; k++) rnd[k*32 +: 32] = $urandom;
            cyc(($urandom_range(0, 63) == 0), NCH'($urandom), AW'($urandom), rnd,
                $urandom_range(0, 1) == 1, AW'($urandom));
        end
        idle(DEPTH + 2);

        chk("queue_drained", 256'(exp_q.size()), '0);
        chk("done_count", 256'(done_seen), 256'(m_done_cnt));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
